// File: rtl/sync_jk_updown_counter.sv
// Parameterised modulo-MOD up/down counter built from parallel JK toggle stages, with load, enable, tc and wrap.
// Latency: q, and the registered wrap pulse, update on the rising clk edge after the inputs are sampled; j, k and tc are combinational.
// Backpressure: none; en=0 holds the count, load is honoured regardless of en, tc can feed a downstream en.
module sync_jk_updown_counter #(
    parameter int WIDTH = 3,
    parameter int MOD   = 2**WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ud,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] nxt;

    // Target state; the stages only ever see it through their toggle excitation.
    always_comb begin
        nxt = q;
        if (load) begin
            nxt = ({1'b0, load_val} < MOD_W) ? load_val : MAX_Q;
        end else if (en) begin
            if (ud) begin
                // q >= MAX_Q also folds corrupted out-of-range states back to 0.
                nxt = (q >= MAX_Q) ? '0 : q + 1'b1;
            end else begin
                nxt = (q == '0) ? MAX_Q : q - 1'b1;
            end
        end
    end

    assign j  = rst ? '0 : (q ^ nxt);
    assign k  = j;
    assign tc = ~rst & en & ~load & ((ud & (q == MAX_Q)) | (~ud & (q == '0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= tc;
            for (int i = 0; i < WIDTH; i++) begin
                case ({j[i], k[i]})
                    2'b01:   q[i] <= 1'b0;
                    2'b10:   q[i] <= 1'b1;
                    2'b11:   q[i] <= ~q[i];
                    default: q[i] <= q[i];
                endcase
            end
        end
    end
endmodule
